// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: stereo PCM FIFO plus Philips I2S serializer (BCLK, LRCK, SDATA).
// Frames are 64 BCLK long. Each channel slot holds the sample MSB first, one BCLK after
// the LRCK edge, and the rest of the slot is zero padded.
module i2s_audio_tx #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int BCLK_DIV   = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic                          pll_locked,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_W-1:0]             s_left,
   input  logic [DATA_W-1:0]             s_right,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   input  logic                          underrun_clr,
   output logic                          frame_tick,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_sdata
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int DIV_W = $clog2(BCLK_DIV);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_STOP_PEND
   } state_t;

   // FIFO storage and bookkeeping
   logic [DATA_W-1:0] mem_left_q  [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_right_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  count_q, count_d;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;

   // Lock synchronizer
   logic locked_meta_q;
   logic locked_sync_q;

   // Serializer state
   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [5:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] left_q, left_d;
   logic [DATA_W-1:0] right_q, right_d;
   logic              bclk_q, bclk_d;
   logic              lrclk_q, lrclk_d;
   logic              sdata_q, sdata_d;
   logic              frame_tick_q, frame_tick_d;
   logic              underrun_q, underrun_d;

   logic              load;
   logic              fall;
   logic              go_idle;
   logic [DATA_W-1:0] chan_word;
   logic [DATA_W-1:0] chan_shifted;
   int                slot;

   assign fifo_full  = (count_q == LVL_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign push       = s_valid && !fifo_full;
   assign pop        = load && !fifo_empty;

   // Double-flop the PLL lock indicator into the clk domain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         locked_meta_q <= 1'b0;
         locked_sync_q <= 1'b0;
      end else begin
         locked_meta_q <= pll_locked;
         locked_sync_q <= locked_meta_q;
      end
   end

   // Sample storage has no reset; the pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_left_q[wr_ptr_q]  <= s_left;
         mem_right_q[wr_ptr_q] <= s_right;
      end
   end

   // FIFO pointer and level updates; a full FIFO refuses a push even when a pop happens
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + LVL_W'(1);
         2'b01:   count_d = count_q - LVL_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Sequencing: counters, frame loads, stop handling and lock loss
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      load      = 1'b0;
      fall      = 1'b0;
      go_idle   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable && locked_sync_q) begin
               state_d   = S_RUN;
               div_cnt_d = '0;
               bit_cnt_d = '0;
               load      = 1'b1;
            end
         end
         default: begin
            if (!locked_sync_q) begin
               go_idle = 1'b1;
            end else begin
               state_d = enable ? S_RUN : S_STOP_PEND;
               if (div_cnt_q == DIV_W'(BCLK_DIV - 1)) begin
                  div_cnt_d = '0;
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  fall      = 1'b1;
                  if (bit_cnt_q == 6'd63) begin
                     if (enable) begin
                        load = 1'b1;
                     end else begin
                        go_idle = 1'b1;
                     end
                  end
               end else begin
                  div_cnt_d = div_cnt_q + DIV_W'(1);
               end
            end
         end
      endcase
      if (go_idle) begin
         state_d   = S_IDLE;
         div_cnt_d = '0;
         bit_cnt_d = '0;
      end
   end

   // Output word selection and next values of the registered I2S pins
   always_comb begin
      left_d       = left_q;
      right_d      = right_q;
      frame_tick_d = load;
      underrun_d   = underrun_q;
      bclk_d       = 1'b0;
      lrclk_d      = 1'b0;
      sdata_d      = 1'b0;
      chan_word    = '0;
      chan_shifted = '0;
      slot         = 0;
      if (load) begin
         left_d  = fifo_empty ? '0 : mem_left_q[rd_ptr_q];
         right_d = fifo_empty ? '0 : mem_right_q[rd_ptr_q];
      end
      if (underrun_clr) begin
         underrun_d = 1'b0;
      end
      if (load && fifo_empty) begin
         underrun_d = 1'b1;
      end
      if (state_d != S_IDLE) begin
         bclk_d  = (div_cnt_d >= DIV_W'(BCLK_DIV / 2));
         lrclk_d = lrclk_q;
         sdata_d = sdata_q;
         if (load || fall) begin
            lrclk_d   = bit_cnt_d[5];
            chan_word = bit_cnt_d[5] ? right_d : left_d;
            slot      = int'(bit_cnt_d[4:0]);
            if (slot >= 1 && slot <= DATA_W) begin
               chan_shifted = chan_word >> (DATA_W - slot);
               sdata_d      = chan_shifted[0];
            end else begin
               sdata_d = 1'b0;
            end
         end
      end
   end

   // State register for FSM, FIFO pointers and all registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         left_q       <= '0;
         right_q      <= '0;
         bclk_q       <= 1'b0;
         lrclk_q      <= 1'b0;
         sdata_q      <= 1'b0;
         frame_tick_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         left_q       <= left_d;
         right_q      <= right_d;
         bclk_q       <= bclk_d;
         lrclk_q      <= lrclk_d;
         sdata_q      <= sdata_d;
         frame_tick_q <= frame_tick_d;
         underrun_q   <= underrun_d;
      end
   end

   assign s_ready    = !fifo_full;
   assign fifo_level = count_q;
   assign underrun   = underrun_q;
   assign frame_tick = frame_tick_q;
   assign i2s_bclk   = bclk_q;
   assign i2s_lrclk  = lrclk_q;
   assign i2s_sdata  = sdata_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Testbench for i2s_audio_tx: table-driven sample pairs feed a scoreboard queue and a
// serial monitor rebuilds each 64-slot frame and compares it against the queue head.
`timescale 1ns/1ps
module tb_i2s_audio_tx;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int LW    = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          pll_locked;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_left;
   logic [DW-1:0] s_right;
   logic [LW-1:0] fifo_level;
   logic          underrun;
   logic          underrun_clr;
   logic          frame_tick;
   logic          i2s_bclk;
   logic          i2s_lrclk;
   logic          i2s_sdata;

   typedef struct {
      logic [DW-1:0] left;
      logic [DW-1:0] right;
      logic [DW-1:0] exp_l;
      logic [DW-1:0] exp_r;
      logic          exp_accept;
   } vec_t;

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
   } pair_t;

   vec_t  vecs [8];
   pair_t exp_q [$];
   pair_t cur_exp;

   int check_cnt = 0;
   int err_cnt   = 0;

   // Monitor state
   logic sd_buf [64];
   logic lr_buf [64];
   logic prev_bclk;
   logic prev_tick;
   logic in_frame;
   logic per_ok;
   int   bit_idx;
   int   cyc;
   int   last_rise;
   int   frames_done;
   int   truncated_cnt;
   logic [DW-1:0] got_l;
   logic [DW-1:0] got_r;
   logic zero_ok;
   logic lr_ok;
   int   k;

   i2s_audio_tx #(
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .BCLK_DIV   (4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .pll_locked   (pll_locked),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_left       (s_left),
      .s_right      (s_right),
      .fifo_level   (fifo_level),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .frame_tick   (frame_tick),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrclk    (i2s_lrclk),
      .i2s_sdata    (i2s_sdata)
   );

   // 100 MHz stand-in for the audio clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one table entry for a single clock; the model accepts it only if it has room
   task automatic applyStimulus(input int idx);
      @(negedge clk);
      s_valid = 1'b1;
      s_left  = vecs[idx].left;
      s_right = vecs[idx].right;
      checkOutput($sformatf("s_ready_vec%0d", idx), 32'(s_ready), 32'(vecs[idx].exp_accept));
      @(posedge clk);
      #1;
      if (exp_q.size() < DEPTH) begin
         exp_q.push_back('{l: vecs[idx].exp_l, r: vecs[idx].exp_r});
      end
   endtask

   task automatic waitFrameTick(input int budget);
      int n = 0;
      logic seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         if (frame_tick) seen = 1'b1;
      end
      checkOutput("frame_tick_seen", 32'(seen), 32'd1);
   endtask

   task automatic waitFrames(input int target, input int budget);
      int n = 0;
      while (frames_done < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("frames_done", 32'(frames_done), 32'(target));
   endtask

   task automatic checkIdle(input string name, input int cycles);
      logic act = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         act = act | i2s_bclk | i2s_lrclk | i2s_sdata | frame_tick;
      end
      checkOutput(name, 32'(act), 32'd0);
   endtask

   // Serial monitor: pops the scoreboard at each frame load and rebuilds the frame from BCLK rises
   always @(negedge clk) begin
      if (!reset_n) begin
         in_frame  = 1'b0;
         bit_idx   = 0;
         prev_bclk = 1'b0;
         prev_tick = 1'b0;
         per_ok    = 1'b1;
      end else begin
         if (prev_tick) begin
            checkOutput("tick_pulse_width", 32'(frame_tick), 32'd0);
         end
         if (frame_tick) begin
            if (in_frame && bit_idx < 64) truncated_cnt++;
            if (exp_q.size() == 0) begin
               cur_exp = '{l: '0, r: '0};
               checkOutput("underrun_on_empty_load", 32'(underrun), 32'd1);
            end else begin
               cur_exp = exp_q.pop_front();
            end
            checkOutput("fifo_level_after_load", 32'(fifo_level), 32'(exp_q.size()));
            checkOutput("s_ready_after_load", 32'(s_ready), 32'(exp_q.size() < DEPTH));
            in_frame = 1'b1;
            bit_idx  = 0;
            per_ok   = 1'b1;
         end
         if (in_frame && i2s_bclk && !prev_bclk && bit_idx < 64) begin
            sd_buf[bit_idx[5:0]] = i2s_sdata;
            lr_buf[bit_idx[5:0]] = i2s_lrclk;
            if (bit_idx > 0 && (cyc - last_rise) != 4) per_ok = 1'b0;
            last_rise = cyc;
            bit_idx++;
            if (bit_idx == 64) begin
               got_l   = '0;
               got_r   = '0;
               zero_ok = 1'b1;
               lr_ok   = 1'b1;
               for (int i = 0; i < 64; i++) begin
                  k = i % 32;
                  if (lr_buf[i[5:0]] != (i >= 32)) lr_ok = 1'b0;
                  if (k >= 1 && k <= DW) begin
                     if (i < 32) got_l = {got_l[DW-2:0], sd_buf[i[5:0]]};
                     else        got_r = {got_r[DW-2:0], sd_buf[i[5:0]]};
                  end else if (sd_buf[i[5:0]]) begin
                     zero_ok = 1'b0;
                  end
               end
               checkOutput("frame_left_word", 32'(got_l), 32'(cur_exp.l));
               checkOutput("frame_right_word", 32'(got_r), 32'(cur_exp.r));
               checkOutput("frame_zero_slots", 32'(zero_ok), 32'd1);
               checkOutput("frame_lrclk_pattern", 32'(lr_ok), 32'd1);
               checkOutput("frame_bclk_period", 32'(per_ok), 32'd1);
               frames_done++;
            end
         end
         prev_bclk = i2s_bclk;
         prev_tick = frame_tick;
      end
      cyc++;
   end

   initial begin
      int fd0;
      int tr0;

      vecs[0] = '{16'hA5A5, 16'h5A5A, 16'b1010010110100101, 16'b0101101001011010, 1'b1};
      vecs[1] = '{16'h8001, 16'h7FFE, 16'b1000000000000001, 16'b0111111111111110, 1'b1};
      vecs[2] = '{16'hFFFF, 16'h0000, 16'b1111111111111111, 16'b0000000000000000, 1'b1};
      vecs[3] = '{16'h1234, 16'hFEDC, 16'b0001001000110100, 16'b1111111011011100, 1'b1};
      vecs[4] = '{16'h0F0F, 16'hF0F0, 16'b0000111100001111, 16'b1111000011110000, 1'b1};
      vecs[5] = '{16'h3C3C, 16'hC3C3, 16'b0011110000111100, 16'b1100001111000011, 1'b0};
      vecs[6] = '{16'h4000, 16'hFFFF, 16'b0100000000000000, 16'b1111111111111111, 1'b1};
      vecs[7] = '{16'h6DB6, 16'h9249, 16'b0110110110110110, 16'b1001001001001001, 1'b1};

      cyc           = 0;
      last_rise     = 0;
      frames_done   = 0;
      truncated_cnt = 0;
      reset_n       = 1'b0;
      enable        = 1'b0;
      pll_locked    = 1'b0;
      s_valid       = 1'b0;
      s_left        = '0;
      s_right       = '0;
      underrun_clr  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_pins", 32'({i2s_bclk, i2s_lrclk, i2s_sdata, frame_tick, underrun}), 32'd0);
      checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
      checkOutput("rst_fifo_level", 32'(fifo_level), 32'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("idle_pins", 32'({i2s_bclk, i2s_lrclk, i2s_sdata, frame_tick, underrun}), 32'd0);
      checkOutput("idle_s_ready", 32'(s_ready), 32'd1);

      // Single pair, then run
      applyStimulus(0);
      @(negedge clk);
      s_valid = 1'b0;
      checkOutput("level_one_pair", 32'(fifo_level), 32'd1);
      enable     = 1'b1;
      pll_locked = 1'b1;
      waitFrameTick(20);

      // Empty FIFO: underrun frames, clear mid-frame, clear coinciding with a load
      waitFrameTick(300);
      repeat (100) @(negedge clk);
      underrun_clr = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("underrun_cleared", 32'(underrun), 32'd0);
      @(negedge clk);
      underrun_clr = 1'b0;
      waitFrameTick(300);
      repeat (100) @(negedge clk);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      checkOutput("underrun_cleared_again", 32'(underrun), 32'd0);
      repeat (154) @(negedge clk);
      underrun_clr = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("clr_on_load_tick", 32'(frame_tick), 32'd1);
      checkOutput("clr_on_load_underrun", 32'(underrun), 32'd1);
      @(negedge clk);
      underrun_clr = 1'b0;
      enable = 1'b0;
      repeat (300) @(negedge clk);
      checkIdle("idle_before_fill", 8);

      // Fill the FIFO in IDLE: fifth push is refused
      for (int i = 1; i <= 5; i++) applyStimulus(i);
      @(negedge clk);
      s_valid = 1'b0;
      checkOutput("level_full", 32'(fifo_level), 32'd4);
      checkOutput("s_ready_full", 32'(s_ready), 32'd0);
      enable = 1'b1;
      for (int i = 0; i < 4; i++) waitFrameTick(300);

      // Stop request at bit_cnt 10 of the last data frame
      fd0 = frames_done;
      tr0 = truncated_cnt;
      repeat (41) @(negedge clk);
      enable = 1'b0;
      waitFrames(fd0 + 1, 300);
      repeat (3) @(negedge clk);
      checkIdle("idle_after_stop", 40);
      checkOutput("stop_no_truncation", 32'(truncated_cnt), 32'(tr0));
      checkOutput("s_ready_drained", 32'(s_ready), 32'd1);

      // Lock loss mid-frame and relock
      applyStimulus(6);
      applyStimulus(7);
      @(negedge clk);
      s_valid = 1'b0;
      checkOutput("level_two_pairs", 32'(fifo_level), 32'd2);
      enable = 1'b1;
      waitFrameTick(20);
      repeat (160) @(negedge clk);
      checkOutput("pre_drop_lrclk", 32'(i2s_lrclk), 32'd1);
      pll_locked = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("lock_drop_pins", 32'({i2s_bclk, i2s_lrclk, i2s_sdata}), 32'd0);
      checkOutput("lock_drop_level", 32'(fifo_level), 32'd1);
      checkIdle("idle_while_unlocked", 20);
      tr0 = truncated_cnt;
      fd0 = frames_done;
      pll_locked = 1'b1;
      waitFrameTick(10);
      #1;
      checkOutput("truncated_frame_seen", 32'(truncated_cnt), 32'(tr0 + 1));
      repeat (50) @(negedge clk);
      enable = 1'b0;
      waitFrames(fd0 + 1, 300);
      repeat (3) @(negedge clk);
      checkIdle("idle_after_relock_frame", 8);

      // Asynchronous reset flushes the FIFO and flags
      applyStimulus(0);
      applyStimulus(1);
      @(negedge clk);
      s_valid = 1'b0;
      checkOutput("level_before_reset", 32'(fifo_level), 32'd2);
      reset_n = 1'b0;
      exp_q.delete();
      #2;
      checkOutput("async_rst_level", 32'(fifo_level), 32'd0);
      checkOutput("async_rst_s_ready", 32'(s_ready), 32'd1);
      checkOutput("async_rst_underrun", 32'(underrun), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
      $finish;
   end

endmodule
